booth_datapath: RTL and testbench
=================================

// Module: booth_datapath
// PURPOSE
//   Radix-2 Booth signed-multiplier datapath; the responder to the control unit's MUL_* states.
//   - Executes the control unit's booth_load/add/sub/shift/count enables.
//   - Returns the status the control unit branches on: booth_bits and booth_counter_done.
//   - Sits beside the adder/subtractor/divider datapaths in the 8-bit ALU.
//   - Exposes the signed 2*WIDTH-bit product.
// PARAMETERS
//   WIDTH   8   operand width in bits (>= 2); product is 2*WIDTH bits
// PORTS
//   clk                 in   1         rising-edge clock
//   reset               in   1         asynchronous, active-high; clears all state
//   multiplicand        in   WIDTH     signed M, sampled only on booth_load
//   multiplier          in   WIDTH     signed Q, sampled only on booth_load
//   booth_load          in   1         load operands, clear accumulator and counter
//   booth_add_en        in   1         A <= A + M
//   booth_sub_en        in   1         A <= A - M
//   booth_shift_en      in   1         arithmetic right shift of {A,Q,Q_1}
//   booth_count_en      in   1         iteration counter increment
//   booth_bits          out  2         {Q[0], Q_1}, combinational from registers
//   booth_counter_done  out  1         high when CNT == WIDTH-1, combinational
//   product             out  2*WIDTH   {A[WIDTH-1:0], Q}, signed result
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - State registers:
//     - A: WIDTH+1 bits. The extra sign bit makes M = -2^(WIDTH-1) correct.
//     - Q: WIDTH bits.
//     - Q_1: 1 bit.
//     - M: WIDTH+1 bits, sign-extended multiplicand.
//     - CNT: clog2(WIDTH)+1 bits.
//   - Reset: all registers 0, so product = 0, booth_bits = 00, booth_counter_done = 0.
//     Reset takes effect immediately at any point, including mid-multiply.
//   - Per-edge update priority (exactly one A/Q update per edge):
//     - booth_load: A <= 0, Q <= multiplier, Q_1 <= 0, M <= sext(multiplicand), CNT <= 0.
//       Overrides every other enable, including count.
//     - else add XOR sub: A <= A +/- M, modulo 2^(WIDTH+1); Q and Q_1 hold. Shift on the same edge is ignored.
//     - else add AND sub both high: illegal; A, Q and Q_1 hold. Shift is ignored.
//     - else shift: {A,Q,Q_1} <= {A[WIDTH], A, Q} >> 0. This is an arithmetic shift by one:
//       - A[WIDTH] is replicated.
//       - A[0] enters Q[WIDTH-1].
//       - Q[0] enters Q_1.
//     - count: independent of add/sub/shift. CNT <= CNT + 1, saturating at WIDTH; it never wraps.
//   - booth_counter_done is read by the controller in its COUNT state, i.e. before that state's increment lands.
//     Hence done = (CNT == WIDTH-1). The controller exits after exactly WIDTH shift/count pairs.
//   - Latency for a controller-driven multiply: 1 load, then WIDTH × (check, optional add/sub, shift, count) cycles.
//     - Best case: 1 + 3*WIDTH cycles to MUL_DONE.
//     - Worst case: 1 + 4*WIDTH cycles to MUL_DONE.
//   - product is valid from the edge after the final shift and holds until the next load or reset.
//     It is undefined-but-deterministic mid-operation, always the raw {A[WIDTH-1:0],Q}.
//   - Enables with no load since reset operate on the zeroed registers; there is no error flag.
//   - Operands are not latched except on booth_load; changes at other times have no effect.
// TESTING
//   - Drive the enables from a bench model of the control unit's MUL sequence in all scenarios below.
//   1. Reset: assert reset asynchronously mid-cycle -> product=0x0000, booth_bits=00, booth_counter_done=0
//      before the next clock edge.
//   2. 7 × 3 -> product=0x0015. booth_counter_done is high only in the 8th count cycle. Exactly 8 shifts occur.
//   3. -5 (0xFB) × 6 -> 0xFFE2 (-30).
//      6 × -5 -> 0xFFE2, checking that add/sub paths are exercised in both roles.
//   4. Boundaries:
//      - -128 × -128 -> 0x4000.
//      - 127 × -128 -> 0xC080.
//      - 0 × -1 -> 0x0000.
//   5. Load multiplier=0x01 -> booth_bits=10 next cycle.
//      Load+count+add on the same edge -> CNT=0 and A=0 (load wins).
//      add+sub together -> A holds.
//   6. Reset after 3 shifts of 7×3 -> all state clears.
//      A following load of 7×3 completes normally with 0x0015.
//      Counting past done saturates CNT (done drops and never reasserts until the next load).

Source files
------------

// File: rtl/booth_datapath.sv
// Radix-2 Booth signed-multiplier datapath: executes the MUL_* enables from the control unit
// and returns {Q[0],Q_1} and the iteration-done status it branches on.
module booth_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 booth_load,
  input  logic                 booth_add_en,
  input  logic                 booth_sub_en,
  input  logic                 booth_shift_en,
  input  logic                 booth_count_en,
  output logic [1:0]           booth_bits,
  output logic                 booth_counter_done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  // A and M carry one extra sign bit so that M = -2^(WIDTH-1) negates without overflow.
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    m_d   = m_q;
    q_d   = q_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;

    if (booth_load) begin
      a_d   = '0;
      q_d   = multiplier;
      q1_d  = 1'b0;
      m_d   = {multiplicand[WIDTH-1], multiplicand};
      cnt_d = '0;
    end else begin
      // Add and sub together is illegal and leaves A/Q/Q_1 untouched; shift is then ignored too.
      if (booth_add_en ^ booth_sub_en) begin
        a_d = booth_add_en ? (a_q + m_q) : (a_q - m_q);
      end else if (!booth_add_en && !booth_sub_en && booth_shift_en) begin
        {a_d, q_d, q1_d} = {a_q[WIDTH], a_q, q_q};
      end

      // Saturate at WIDTH so that done can never reassert before the next load.
      if (booth_count_en && (cnt_q != CntW'(WIDTH))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      m_q   <= m_d;
      q_q   <= q_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
    end
  end

  // The controller samples done in its COUNT state, before that state's increment lands.
  assign booth_counter_done = (cnt_q == CntW'(WIDTH - 1));
  assign booth_bits         = {q_q[0], q1_q};
  assign product            = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_booth_datapath.sv
// Bench for booth_datapath: a control-unit model drives the MUL sequence; expected values are
// pushed to a scoreboard queue and a separate monitor pops and compares them.
module tb_booth_datapath;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   multiplicand, multiplier;
  logic           booth_load, booth_add_en, booth_sub_en, booth_shift_en, booth_count_en;
  logic [1:0]     booth_bits;
  logic           booth_counter_done;
  logic [2*W-1:0] product;

  booth_datapath #(.WIDTH(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .multiplicand       (multiplicand),
    .multiplier         (multiplier),
    .booth_load         (booth_load),
    .booth_add_en       (booth_add_en),
    .booth_sub_en       (booth_sub_en),
    .booth_shift_en     (booth_shift_en),
    .booth_count_en     (booth_count_en),
    .booth_bits         (booth_bits),
    .booth_counter_done (booth_counter_done),
    .product            (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 product, 1 booth_bits, 2 done, 3 bench-observed value
    logic [31:0] exp;
    logic [31:0] act;
    string       name;
  } sb_item_t;

  sb_item_t sb_q[$];
  event     sample_ev;
  int       n_checks = 0;
  int       n_passed = 0;

  // Monitor: pops every pending expectation when the stimulus side presents a sample point.
  always begin
    @(sample_ev);
    while (sb_q.size() != 0) begin
      sb_item_t    it;
      logic [31:0] act;
      it = sb_q.pop_front();
      case (it.kind)
        0:       act = 32'(product);
        1:       act = 32'(booth_bits);
        2:       act = 32'(booth_counter_done);
        default: act = it.act;
      endcase
      n_checks++;
      if (act === it.exp) n_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", it.name, act, it.exp, $time);
    end
  end

  task automatic expect_sig(input int kind, input logic [31:0] exp, input string name);
    sb_item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.act  = '0;
    it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic expect_val(input logic [31:0] act, input logic [31:0] exp, input string name);
    sb_item_t it;
    it.kind = 3;
    it.exp  = exp;
    it.act  = act;
    it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic sample();
    ->sample_ev;
    #1;
  endtask

  // One clock with the given enables; operands are randomised whenever load is low.
  task automatic cyc(input bit ld, ad, sb, sh, ct, input logic [W-1:0] mc, mp);
    booth_load     = ld;
    booth_add_en   = ad;
    booth_sub_en   = sb;
    booth_shift_en = sh;
    booth_count_en = ct;
    if (ld) begin
      multiplicand = mc;
      multiplier   = mp;
    end else begin
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    {booth_load, booth_add_en, booth_sub_en, booth_shift_en, booth_count_en} = '0;
  endtask

  task automatic reset_midcycle(input string tag);
    #2 reset = 1'b1;
    #1;
    expect_sig(0, 32'h0, {tag, "_product"});
    expect_sig(1, 32'h0, {tag, "_bits"});
    expect_sig(2, 32'h0, {tag, "_done"});
    sample();
    reset = 1'b0;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] ea, eb;
    ea = {{W{a[W-1]}}, a};
    eb = {{W{b[W-1]}}, b};
    return ea * eb;
  endfunction

  // Control-unit model: LOAD, then CHECK / optional ADD|SUB / SHIFT / COUNT until done.
  task automatic do_mul(input logic [W-1:0] mc, mp, input int abort_at, input string tag);
    int n_shift;
    bit fin;
    bit d;
    n_shift = 0;
    fin     = 1'b0;
    cyc(1, 0, 0, 0, 0, mc, mp);
    for (int it = 0; it < 2 * W && !fin; it++) begin
      if (it < W) begin
        expect_sig(1, {30'h0, mp[it], (it == 0) ? 1'b0 : mp[it-1]}, {tag, "_bits"});
        sample();
      end
      cyc(0, 0, 0, 0, 0, '0, '0);
      if (booth_bits == 2'b01) cyc(0, 1, 0, 0, 0, '0, '0);
      else if (booth_bits == 2'b10) cyc(0, 0, 1, 0, 0, '0, '0);
      cyc(0, 0, 0, 1, 0, '0, '0);
      n_shift++;
      if (n_shift == abort_at) begin
        reset_midcycle({tag, "_abort"});
        return;
      end
      expect_sig(2, (it == W - 1) ? 32'h1 : 32'h0, {tag, "_done"});
      sample();
      d = booth_counter_done;
      cyc(0, 0, 0, 0, 1, '0, '0);
      if (d) fin = 1'b1;
    end
    if (!fin) $display("FAIL %s_timeout: got no done, expected done within %0d iterations", tag, W);
    expect_val(32'(n_shift), 32'(W), {tag, "_shifts"});
    expect_sig(0, 32'(ref_mul(mc, mp)), {tag, "_product"});
    sample();
  endtask

  initial begin
    reset = 1'b1;
    {booth_load, booth_add_en, booth_sub_en, booth_shift_en, booth_count_en} = '0;
    multiplicand = '0;
    multiplier   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expect_sig(0, 32'h0, "reset_product");
    expect_sig(1, 32'h0, "reset_bits");
    expect_sig(2, 32'h0, "reset_done");
    sample();

    // Busy state then asynchronous reset between edges.
    cyc(1, 0, 0, 0, 0, 8'h7F, 8'h81);
    cyc(0, 1, 0, 0, 0, '0, '0);
    for (int k = 0; k < W - 1; k++) cyc(0, 0, 0, 0, 1, '0, '0);
    expect_sig(2, 32'h1, "pre_reset_done");
    expect_sig(0, 32'h7F81, "pre_reset_product");
    sample();
    reset_midcycle("async_reset");

    do_mul(8'd7, 8'd3, -1, "mul_7x3");
    do_mul(8'hFB, 8'd6, -1, "mul_m5x6");
    do_mul(8'd6, 8'hFB, -1, "mul_6xm5");
    do_mul(8'h80, 8'h80, -1, "mul_m128xm128");
    do_mul(8'h7F, 8'h80, -1, "mul_127xm128");
    do_mul(8'h00, 8'hFF, -1, "mul_0xm1");

    // Single-edge priority cases.
    cyc(1, 0, 0, 0, 0, 8'h05, 8'h01);
    expect_sig(1, 32'h2, "load_q1_bits");
    sample();
    cyc(1, 1, 0, 1, 1, 8'h05, 8'h33);
    expect_sig(0, 32'h0033, "load_wins_product");
    expect_sig(2, 32'h0, "load_wins_done");
    sample();
    for (int k = 1; k <= W - 1; k++) begin
      cyc(0, 0, 0, 0, 1, '0, '0);
      expect_sig(2, (k == W - 1) ? 32'h1 : 32'h0, "cnt_from_zero_done");
      sample();
    end
    cyc(0, 1, 0, 1, 0, '0, '0);
    expect_sig(0, 32'h0533, "add_ignores_shift");
    sample();
    cyc(0, 1, 1, 1, 0, '0, '0);
    expect_sig(0, 32'h0533, "add_sub_hold_product");
    expect_sig(1, 32'h2, "add_sub_hold_bits");
    sample();

    // Reset mid-multiply, then a clean rerun and counting past done.
    do_mul(8'd7, 8'd3, 3, "mul_abort");
    do_mul(8'd7, 8'd3, -1, "mul_7x3_rerun");
    for (int k = 0; k < 2 * W + 4; k++) begin
      cyc(0, 0, 0, 0, 1, '0, '0);
      expect_sig(2, 32'h0, "saturate_done");
      sample();
    end
    expect_sig(0, 32'h0015, "saturate_product_hold");
    sample();

    for (int r = 0; r < 30; r++) do_mul(W'($urandom), W'($urandom), -1, "mul_rand");

    #1;
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
